// File: rtl/audio_pkg.sv
// Shared constants and types for the I2S audio path.
package audio_pkg;

  localparam int unsigned CNT_W    = 9;
  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned SLOTS    = 32;
  localparam int unsigned SLOT_W   = 5;
  localparam int unsigned SLOT_LSB = 4;
  localparam int unsigned FRAME_W  = 2 * SAMPLE_W;

  localparam int unsigned MCLK_BIT = 1;
  localparam int unsigned SCK_BIT  = 3;
  localparam int unsigned LRCK_BIT = 8;

  localparam int unsigned FMT_I2S = 0;
  localparam int unsigned FMT_LJ  = 1;

  localparam logic [CNT_W-1:0] CNT_LAST = '1;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // Frame bit index carried by a given slot in I2S format (valid for slot 1..31).
  function automatic logic [SLOT_W-1:0] i2s_bit_idx(input logic [SLOT_W-1:0] slot);
    return SLOT_W'((SLOT_W + 1)'(SLOTS) - (SLOT_W + 1)'(slot));
  endfunction

endpackage

// File: rtl/i2s_speaker_tx_if.sv
// Sample inputs from the note generator and the Pmod I2S DAC pins.
interface i2s_speaker_tx_if;
  import audio_pkg::*;

  sample_t audio_left;
  sample_t audio_right;
  logic    mute;
  logic    audio_mclk;
  logic    audio_lrck;
  logic    audio_sck;
  logic    audio_sdin;
  logic    sample_tick;

  // Upstream side: supplies samples, observes the DAC pins and capture tick.
  modport master (
    output audio_left, audio_right, mute,
    input  audio_mclk, audio_lrck, audio_sck, audio_sdin, sample_tick
  );

  // Transmitter side.
  modport slave (
    input  audio_left, audio_right, mute,
    output audio_mclk, audio_lrck, audio_sck, audio_sdin, sample_tick
  );
endinterface

// File: rtl/i2s_clk_gen.sv
// Free-running frame counter and the DAC clocks derived from its bits.
module i2s_clk_gen
  import audio_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  output logic              mclk,
  output logic              sck,
  output logic              lrck,
  output logic              tick,
  output logic [SLOT_W-1:0] slot,
  output logic              capture_c,
  output logic              slot_end_c
);

  logic [CNT_W-1:0] cnt;

  // Counter wraps naturally at 2^CNT_W; tick is registered so it is high while cnt == last.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= cnt + CNT_W'(1);
      tick <= (cnt == CNT_LAST - CNT_W'(1));
    end
  end

  assign mclk       = cnt[MCLK_BIT];
  assign sck        = cnt[SCK_BIT];
  assign lrck       = cnt[LRCK_BIT];
  assign slot       = cnt[LRCK_BIT:SLOT_LSB];
  assign capture_c  = (cnt == CNT_LAST);
  assign slot_end_c = &cnt[SLOT_LSB-1:0];

endmodule

// File: rtl/i2s_speaker_tx.sv
// Captures a stereo sample per frame and serialises it onto the I2S DAC pins.
module i2s_speaker_tx
  import audio_pkg::*;
#(
  parameter int unsigned FORMAT = FMT_I2S
)(
  input  logic             clk,
  input  logic             rst,
  i2s_speaker_tx_if.slave  bus
);

  logic              mclk, sck, lrck, tick;
  logic [SLOT_W-1:0] slot;
  logic              capture_c, slot_end_c;

  sample_t             shadow_l, shadow_r;
  sample_t             shadow_l_nxt, shadow_r_nxt;
  logic                prev_r_lsb, prev_r_lsb_nxt;
  logic [FRAME_W-1:0]  frame_nxt;
  logic [SLOT_W-1:0]   slot_nxt;
  logic                sdin, sdin_nxt_c;

  i2s_clk_gen u_clk_gen (
    .clk        (clk),
    .rst        (rst),
    .mclk       (mclk),
    .sck        (sck),
    .lrck       (lrck),
    .tick       (tick),
    .slot       (slot),
    .capture_c  (capture_c),
    .slot_end_c (slot_end_c)
  );

  // Next shadow state: load (or zero on mute) only on the capture cycle.
  always_comb begin
    shadow_l_nxt   = shadow_l;
    shadow_r_nxt   = shadow_r;
    prev_r_lsb_nxt = prev_r_lsb;
    if (capture_c) begin
      shadow_l_nxt   = bus.mute ? '0 : bus.audio_left;
      shadow_r_nxt   = bus.mute ? '0 : bus.audio_right;
      prev_r_lsb_nxt = shadow_r[0];
    end
  end

  // Bit for the upcoming slot, taken from next-state shadows so slot 0 sees a fresh capture.
  always_comb begin
    frame_nxt  = {shadow_l_nxt, shadow_r_nxt};
    slot_nxt   = slot + SLOT_W'(1);
    sdin_nxt_c = 1'b0;
    if (FORMAT == FMT_LJ) begin
      sdin_nxt_c = frame_nxt[~slot_nxt];
    end else if (slot_nxt == '0) begin
      sdin_nxt_c = prev_r_lsb_nxt;
    end else begin
      sdin_nxt_c = frame_nxt[i2s_bit_idx(slot_nxt)];
    end
  end

  // Shadow registers and serial data; sdin changes only at sck falling edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_l   <= '0;
      shadow_r   <= '0;
      prev_r_lsb <= 1'b0;
      sdin       <= 1'b0;
    end else begin
      shadow_l   <= shadow_l_nxt;
      shadow_r   <= shadow_r_nxt;
      prev_r_lsb <= prev_r_lsb_nxt;
      if (slot_end_c) begin
        sdin <= sdin_nxt_c;
      end
    end
  end

  assign bus.audio_mclk  = mclk;
  assign bus.audio_sck   = sck;
  assign bus.audio_lrck  = lrck;
  assign bus.audio_sdin  = sdin;
  assign bus.sample_tick = tick;

endmodule

// File: tb/tb_i2s_speaker_tx.sv
// Directed bench: left-justified and I2S instances driven with identical samples.
module tb_i2s_speaker_tx;

  logic clk;
  logic rst;
  logic [8:0] cnt_m;
  int tests;
  int fails;

  i2s_speaker_tx_if if_lj ();
  i2s_speaker_tx_if if_i2s ();

  i2s_speaker_tx #(.FORMAT(1)) dut_lj  (.clk(clk), .rst(rst), .bus(if_lj));
  i2s_speaker_tx #(.FORMAT(0)) dut_i2s (.clk(clk), .rst(rst), .bus(if_i2s));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic        m;
    int          pulse_at;
    int          chg_at;
    logic [15:0] chg_l;
    logic [31:0] exp_lj;
    logic [31:0] exp_i2s;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_left(input logic [15:0] l);
    if_lj.audio_left  = l;
    if_i2s.audio_left = l;
  endtask

  task automatic set_in(input logic [15:0] l, input logic [15:0] r, input logic m);
    set_left(l);
    if_lj.audio_right  = r;
    if_i2s.audio_right = r;
    if_lj.mute  = m;
    if_i2s.mute = m;
  endtask

  task automatic set_mute(input logic m);
    if_lj.mute  = m;
    if_i2s.mute = m;
  endtask

  // Advance one clock; bench sits on negedges, away from the active edge.
  task automatic step();
    @(negedge clk);
    cnt_m = cnt_m + 9'd1;
  endtask

  task automatic run_to(input int t);
    int n;
    n = 0;
    while (int'(cnt_m) != t && n < 1024) begin
      step();
      n++;
    end
    if (n >= 1024) chk("run_to_timeout", 32'(n), 32'(0));
  endtask

  // Collect one frame starting at cnt==0, sampling sdin mid-slot (sck high).
  task automatic collect(input int chg_at, input logic [15:0] chg_l,
                         output logic [31:0] lj, output logic [31:0] i2s);
    lj  = '0;
    i2s = '0;
    for (int s = 0; s < 32; s++) begin
      int n;
      n = 0;
      while (int'(cnt_m) != 16 * s + 8 && n < 1024) begin
        if (int'(cnt_m) == chg_at) set_left(chg_l);
        step();
        n++;
      end
      if (n >= 1024) chk("collect_timeout", 32'(n), 32'(0));
      lj[31-s]  = if_lj.audio_sdin;
      i2s[31-s] = if_i2s.audio_sdin;
    end
  endtask

  task automatic do_frame(input vec_t v, output logic [31:0] lj, output logic [31:0] i2s);
    set_in(v.l, v.r, 1'b0);
    if (v.pulse_at >= 0) begin
      run_to(v.pulse_at);
      set_mute(1'b1);
      step();
      set_mute(1'b0);
    end
    run_to(511);
    set_mute(v.m);
    step();
    set_mute(1'b0);
    collect(v.chg_at, v.chg_l, lj, i2s);
  endtask

  initial begin
    logic [31:0] lj, i2s;
    int e_mclk, e_sck, e_lrck, e_tick, ticks, ones, tick_pos;

    tests = 0;
    fails = 0;
    cnt_m = '0;
    rst   = 1'b0;
    set_in(16'h0, 16'h0, 1'b0);

    //                l        r        m     pulse chg  chg_l    exp_lj        exp_i2s
    vecs[0] = '{16'h1234, 16'h0001, 1'b0, -1, -1,  16'h0, 32'h12340001, 32'h091A0000};
    vecs[1] = '{16'hF000, 16'h1000, 1'b0, -1, -1,  16'h0, 32'hF0001000, 32'hF8000800};
    vecs[2] = '{16'h8000, 16'h0001, 1'b0, -1, -1,  16'h0, 32'h80000001, 32'h40000000};
    vecs[3] = '{16'hC000, 16'h4000, 1'b1, -1, -1,  16'h0, 32'h00000000, 32'h80000000};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b0, -1, -1,  16'h0, 32'hFFFFFFFF, 32'h7FFFFFFF};
    vecs[5] = '{16'h7FFF, 16'h8000, 1'b0, -1, -1,  16'h0, 32'h7FFF8000, 32'hBFFFC000};
    vecs[6] = '{16'hA000, 16'h0000, 1'b0, -1, 200, 16'h5000, 32'hA0000000, 32'h50000000};
    vecs[7] = '{16'h5000, 16'h0000, 1'b0, -1, -1,  16'h0, 32'h50000000, 32'h28000000};
    vecs[8] = '{16'hC000, 16'h4000, 1'b0, 100, -1, 16'h0, 32'hC0004000, 32'h60002000};

    // Reset held 10 cycles: every output low.
    repeat (10) @(negedge clk);
    chk("reset_outputs",
        32'({if_lj.audio_mclk, if_lj.audio_sck, if_lj.audio_lrck, if_lj.sample_tick,
             if_lj.audio_sdin, if_i2s.audio_sdin}), 32'h0);
    rst   = 1'b1;
    cnt_m = '0;

    // Clock relationships over two frames.
    e_mclk = 0; e_sck = 0; e_lrck = 0; e_tick = 0; ticks = 0;
    for (int i = 0; i < 1024; i++) begin
      if (if_lj.audio_mclk !== cnt_m[1]) e_mclk++;
      if (if_lj.audio_sck  !== cnt_m[3]) e_sck++;
      if (if_lj.audio_lrck !== cnt_m[8]) e_lrck++;
      if (if_lj.sample_tick !== (cnt_m == 9'd511)) e_tick++;
      if (if_lj.sample_tick === 1'b1) ticks++;
      step();
    end
    chk("mclk_pattern_errs", 32'(e_mclk), 32'h0);
    chk("sck_pattern_errs",  32'(e_sck),  32'h0);
    chk("lrck_pattern_errs", 32'(e_lrck), 32'h0);
    chk("tick_pattern_errs", 32'(e_tick), 32'h0);
    chk("tick_count_2frames", 32'(ticks), 32'd2);

    // Table of frames: serialised words for both formats.
    for (int i = 0; i < 9; i++) begin
      do_frame(vecs[i], lj, i2s);
      chk($sformatf("vec%0d_lj", i),  lj,  vecs[i].exp_lj);
      chk($sformatf("vec%0d_i2s", i), i2s, vecs[i].exp_i2s);
    end

    // Reset in the middle of the right slot.
    set_in(16'hFFFF, 16'hFFFF, 1'b0);
    run_to(511);
    step();
    run_to(300);
    chk("pre_reset_lrck", 32'(if_lj.audio_lrck), 32'h1);
    chk("pre_reset_sdin", 32'(if_lj.audio_sdin), 32'h1);
    rst = 1'b0;
    #1;
    chk("mid_reset_outputs",
        32'({if_lj.audio_mclk, if_lj.audio_sck, if_lj.audio_lrck, if_lj.sample_tick,
             if_lj.audio_sdin, if_i2s.audio_sdin}), 32'h0);
    repeat (3) @(negedge clk);
    rst   = 1'b1;
    cnt_m = '0;
    ones = 0; ticks = 0; tick_pos = -1;
    for (int i = 0; i < 512; i++) begin
      if (if_lj.audio_sdin === 1'b1 || if_i2s.audio_sdin === 1'b1) ones++;
      if (if_lj.sample_tick === 1'b1) begin
        ticks++;
        tick_pos = i;
      end
      step();
    end
    chk("post_reset_ones", 32'(ones), 32'h0);
    chk("post_reset_ticks", 32'(ticks), 32'h1);
    chk("post_reset_tick_pos", 32'(tick_pos), 32'd511);
    chk("lj_first_bit_cnt0", 32'(if_lj.audio_sdin), 32'h1);
    run_to(8);
    chk("i2s_slot0_prev_zero", 32'(if_i2s.audio_sdin), 32'h0);
    run_to(16);
    chk("i2s_msb_cnt16", 32'(if_i2s.audio_sdin), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2s_speaker_tx.md
Name: i2s_speaker_tx

Overview:
Downstream stage of the note generator. It takes the 16-bit signed left/right audio samples and serialises them onto the Pmod I2S DAC pins: master clock, word-select, serial bit clock and serial data. All DAC clocks come from one free-running counter, so every output is glitch-free and has a fixed phase relationship to the others. Samples are captured once per frame and announced with a one-cycle tick.

Parameters:
FORMAT, 0, serial data format: 0 = I2S (1-bit delay after lrck edge), 1 = left-justified (MSB coincident with lrck edge)

Ports:
clk  in  1  100 MHz system clock
rst  in  1  asynchronous, active-low reset
audio_left  in  16  two's-complement left sample, free-running
audio_right  in  16  two's-complement right sample, free-running
mute  in  1  when high at frame capture, both captured samples forced to 0
audio_mclk  out  1  DAC master clock, clk/4 (25 MHz)
audio_lrck  out  1  word select, clk/512 (~195.3 kHz); 0 = left slot, 1 = right slot
audio_sck  out  1  serial bit clock, clk/16 (6.25 MHz), 32 sck per frame
audio_sdin  out  1  serial data, MSB first, changes on sck falling edge
sample_tick  out  1  one-cycle pulse on the capture cycle (cnt == 511)

Behaviour:
- Frame counter: cnt[8:0], increments by 1 every clk and wraps 511 -> 0.
- Clock outputs, taken straight from register bits: audio_mclk = cnt[1], audio_sck = cnt[3], audio_lrck = cnt[8].
- Slot index: s = cnt[8:4], range 0..31; each slot lasts 16 clk.
- Capture:
  - On the cycle where cnt == 511, sample_tick = 1.
  - On the same clock edge, shadow_l and shadow_r load audio_left and audio_right, or 0 if mute = 1.
  - The old shadow_r[0] is saved to prev_r_lsb at the same edge.
  - Inputs are ignored on every other cycle; changes mid-frame do not affect the frame being sent.
- Frame word: F = {shadow_l, shadow_r}, 32 bits.
- audio_sdin for slot s:
  - FORMAT = 1: F[31-s].
  - FORMAT = 0: s = 0 -> prev_r_lsb; s = 1..31 -> F[32-s]. Left MSB is at slot 1, left LSB at slot 16 (lrck already 1), right MSB at slot 17.
- audio_sdin is registered. It updates on the clk edge where cnt[3:0] == 15, i.e. coincident with the sck falling edge, and holds for the whole slot. The DAC samples on the sck rising edge, 8 clk into the slot.
- Latency: the sample present at cnt == 511 puts its first bit on audio_sdin in the cycle where cnt == 0.
  - FORMAT = 1: left MSB at cnt == 0.
  - FORMAT = 0: left MSB at cnt == 16.
- Register wrap: the F[31-s] and F[32-s] values for slot 0 of the next frame are computed from the newly loaded shadow registers (same-edge load and serialise). The next-slot mux must use the next-state shadow value.
- mute is sampled only at capture. Asserting it mid-frame completes the current frame unchanged.
- Reset: rst = 0 immediately clears cnt, shadow_l, shadow_r, prev_r_lsb, audio_sdin and sample_tick to 0. All clock outputs therefore read 0. Reset release mid-frame restarts the frame at cnt = 0 with zero samples; the first real capture occurs at cnt == 511.
- No back-pressure: upstream holds its value; the note generator's combinational outputs are valid every cycle.

Decomposition:
- Shared package audio_pkg:
  - CNT_W = 9, SAMPLE_W = 16, SLOTS = 32
  - bit positions MCLK_BIT = 1, SCK_BIT = 3, LRCK_BIT = 8
  - format constants FMT_I2S = 0, FMT_LJ = 1
- Sub-module i2s_clk_gen: the frame counter plus the derived mclk/sck/lrck/tick/slot outputs. It is reusable by a future receive path.
- Serialiser and capture logic stay in i2s_speaker_tx.

Test Plan:
1. Reset held 10 cycles, then released -> all outputs 0 during reset. After release: mclk period 4 clk, sck period 16 clk, lrck period 512 clk with 50% duty, sample_tick exactly once per 512 clk at cnt == 511.
2. FORMAT = 1, audio_left = 16'hF000, audio_right = 16'h1000 -> sampling sdin at sck rising edges gives 32 bits 1111_0000_0000_0000 0001_0000_0000_0000. The first bit is valid at cnt == 0.
3. FORMAT = 0, same samples, previous right LSB = 1 (prior frame right = 16'h0001) -> slot 0 = 1, slots 1..16 = 16'hF000 MSB-first, slots 17..31 = 16'h1000[15:1].
4. audio_left changes from 16'hA000 to 16'h5000 at cnt == 200 -> current frame still sends A000; next frame sends 5000.
5. mute = 1 only on the capture cycle, inputs 16'hC000 / 16'h4000 -> next frame's sdin is all zeros (LJ). A mute pulse at cnt == 100 has no effect.
6. rst asserted at cnt == 300 mid-right-slot -> sdin, clocks and tick are 0 immediately. After release, the first non-zero bit appears only after the first tick (512 clk later).
